note_player_fsm: RTL and testbench

- Sits directly downstream of the song reader.
- Accepts one note per `new_note` pulse and holds it for `duration` beats, where a beat is the 1/48 s strobe.
- Drives a phase accumulator whose upper bits address the downstream sine/sample stage.
- Pulses `note_done` back to the song reader when the note expires, and honours `play` for pause and resume.

---
 rtl/note_player_fsm_pkg.sv | 37 +++
 rtl/note_player_fsm_if.sv | 42 ++++
 rtl/note_player_fsm_lut.sv | 105 ++++++++++
 rtl/note_player_fsm.sv | 112 +++++++++++
 tb/tb_note_player_fsm.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/note_player_fsm_pkg.sv
// -----------------------------------------------------------------------------
// note_player_fsm_pkg
// Shared definitions for the note player and its neighbours (the song reader
// uses the same note/duration/metadata widths).
//   - Field widths: NOTE_W, DUR_W, META_W, STEP_W, PHASE_W
//   - Rates: SAMPLE_RATE (output samples per second), BEAT_RATE (beats per s)
//   - FSM state encodings NP_IDLE / NP_LOAD / NP_PLAY / NP_DONE (2-bit)
//   - phase_advance(): modulo-2^PHASE_W phase accumulation step
// -----------------------------------------------------------------------------
package note_player_fsm_pkg;

    localparam int NOTE_W      = 6;
    localparam int DUR_W       = 6;
    localparam int META_W      = 3;
    localparam int STEP_W      = 20;
    localparam int PHASE_W     = 22;

    localparam int SAMPLE_RATE = 48000;
    localparam int BEAT_RATE   = 48;

    typedef logic [1:0] np_state_t;

    localparam logic [1:0] NP_IDLE = 2'd0;
    localparam logic [1:0] NP_LOAD = 2'd1;
    localparam logic [1:0] NP_PLAY = 2'd2;
    localparam logic [1:0] NP_DONE = 2'd3;

    // The sum is truncated to PHASE_W bits, so the accumulator wraps naturally;
    // a wrap is just the start of the next waveform period.
    function automatic logic [PHASE_W-1:0] phase_advance(
        input logic [PHASE_W-1:0] phase,
        input logic [STEP_W-1:0]  step
    );
        return phase + PHASE_W'(step);
    endfunction

endpackage

// File: rtl/note_player_fsm_if.sv
// -----------------------------------------------------------------------------
// note_player_fsm_if
// Bundles the song-reader-facing strobes/fields and the player outputs.
//   master : song reader / timing side (drives play, strobes and note fields)
//   slave  : note_player_fsm (drives note_done, busy, cur_metadata, step_size,
//            phase and the dbg_state observation port)
//
// Handshake semantics: there is no back-pressure on this bus. new_note, beat
// and sample_tick are single-cycle strobes sampled on the rising clock edge;
// note, duration and metadata are only meaningful in a cycle where new_note=1
// and are captured on that edge. note_done is a single-cycle strobe back to
// the song reader; the reader may answer with new_note in that same cycle.
// -----------------------------------------------------------------------------
interface note_player_fsm_if;
    import note_player_fsm_pkg::*;

    logic              play;
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic [META_W-1:0] metadata;
    logic              beat;
    logic              sample_tick;

    logic               note_done;
    logic               busy;
    logic [META_W-1:0]  cur_metadata;
    logic [STEP_W-1:0]  step_size;
    logic [PHASE_W-1:0] phase;
    np_state_t          dbg_state;

    modport master (
        output play, new_note, note, duration, metadata, beat, sample_tick,
        input  note_done, busy, cur_metadata, step_size, phase, dbg_state
    );

    modport slave (
        input  play, new_note, note, duration, metadata, beat, sample_tick,
        output note_done, busy, cur_metadata, step_size, phase, dbg_state
    );

endinterface

// File: rtl/note_player_fsm_lut.sv
// -----------------------------------------------------------------------------
// note_step_lut
// 64-entry registered ROM: note index -> phase increment per output sample.
//   clk     : system clock
//   reset   : asynchronous active-low reset (clears the output register)
//   i_note  : note index (0 = silence)
//   o_step  : registered phase step, valid one edge after i_note settles
//
// Entries follow an equal-tempered scale around A4 = note 49, scaled so that
// note 49 maps to 38449 (one octave = exact doubling of the step, so note 37
// is 19224 and note 61 is 76898). Note 0 is silence and yields step 0.
// -----------------------------------------------------------------------------
module note_step_lut
    import note_player_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] i_note,
    output logic [STEP_W-1:0] o_step
);

    logic [STEP_W-1:0] w_rom_data;
    logic [STEP_W-1:0] r_step;

    always_comb begin
        w_rom_data = '0;
        case (i_note)
            6'd1:  w_rom_data = 20'd2403;
            6'd2:  w_rom_data = 20'd2546;
            6'd3:  w_rom_data = 20'd2697;
            6'd4:  w_rom_data = 20'd2858;
            6'd5:  w_rom_data = 20'd3028;
            6'd6:  w_rom_data = 20'd3208;
            6'd7:  w_rom_data = 20'd3398;
            6'd8:  w_rom_data = 20'd3601;
            6'd9:  w_rom_data = 20'd3815;
            6'd10: w_rom_data = 20'd4041;
            6'd11: w_rom_data = 20'd4282;
            6'd12: w_rom_data = 20'd4536;
            6'd13: w_rom_data = 20'd4806;
            6'd14: w_rom_data = 20'd5092;
            6'd15: w_rom_data = 20'd5395;
            6'd16: w_rom_data = 20'd5715;
            6'd17: w_rom_data = 20'd6055;
            6'd18: w_rom_data = 20'd6415;
            6'd19: w_rom_data = 20'd6797;
            6'd20: w_rom_data = 20'd7201;
            6'd21: w_rom_data = 20'd7629;
            6'd22: w_rom_data = 20'd8083;
            6'd23: w_rom_data = 20'd8563;
            6'd24: w_rom_data = 20'd9073;
            6'd25: w_rom_data = 20'd9612;
            6'd26: w_rom_data = 20'd10184;
            6'd27: w_rom_data = 20'd10789;
            6'd28: w_rom_data = 20'd11431;
            6'd29: w_rom_data = 20'd12111;
            6'd30: w_rom_data = 20'd12831;
            6'd31: w_rom_data = 20'd13594;
            6'd32: w_rom_data = 20'd14402;
            6'd33: w_rom_data = 20'd15258;
            6'd34: w_rom_data = 20'd16166;
            6'd35: w_rom_data = 20'd17127;
            6'd36: w_rom_data = 20'd18145;
            6'd37: w_rom_data = 20'd19224;
            6'd38: w_rom_data = 20'd20368;
            6'd39: w_rom_data = 20'd21579;
            6'd40: w_rom_data = 20'd22862;
            6'd41: w_rom_data = 20'd24221;
            6'd42: w_rom_data = 20'd25661;
            6'd43: w_rom_data = 20'd27187;
            6'd44: w_rom_data = 20'd28804;
            6'd45: w_rom_data = 20'd30517;
            6'd46: w_rom_data = 20'd32331;
            6'd47: w_rom_data = 20'd34254;
            6'd48: w_rom_data = 20'd36291;
            6'd49: w_rom_data = 20'd38449;
            6'd50: w_rom_data = 20'd40735;
            6'd51: w_rom_data = 20'd43157;
            6'd52: w_rom_data = 20'd45724;
            6'd53: w_rom_data = 20'd48442;
            6'd54: w_rom_data = 20'd51323;
            6'd55: w_rom_data = 20'd54375;
            6'd56: w_rom_data = 20'd57608;
            6'd57: w_rom_data = 20'd61034;
            6'd58: w_rom_data = 20'd64663;
            6'd59: w_rom_data = 20'd68508;
            6'd60: w_rom_data = 20'd72582;
            6'd61: w_rom_data = 20'd76898;
            6'd62: w_rom_data = 20'd81470;
            6'd63: w_rom_data = 20'd86315;
            default: w_rom_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step <= '0;
        end else begin
            r_step <= w_rom_data;
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/note_player_fsm.sv
// -----------------------------------------------------------------------------
// note_player_fsm
// Plays one note at a time for the song reader: latches note/duration/metadata
// on new_note, counts beats until the duration expires, and advances a phase
// accumulator by the note's step on every sample tick while playing.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : note_player_fsm_if.slave
//              in : play, new_note, note, duration, metadata, beat, sample_tick
//              out: note_done, busy, cur_metadata, step_size, phase, dbg_state
//
// State flow: IDLE -> LOAD -> PLAY -> DONE -> IDLE. A new_note in any state
// restarts at LOAD with the new fields; an abandoned note never reports
// note_done. A zero duration goes straight from LOAD to DONE.
// -----------------------------------------------------------------------------
module note_player_fsm
    import note_player_fsm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    note_player_fsm_if.slave bus
);

    np_state_t          r_state;
    np_state_t          w_state_nxt;
    logic [NOTE_W-1:0]  r_note;
    logic [DUR_W-1:0]   r_dur;
    logic [META_W-1:0]  r_meta;
    logic [DUR_W-1:0]   r_beat_cnt;
    logic [PHASE_W-1:0] r_phase;

    logic [STEP_W-1:0]  w_lut_step;
    logic [STEP_W-1:0]  w_step_out;
    logic [DUR_W-1:0]   w_cnt_inc;
    logic               w_beat_en;
    logic               w_tick_en;
    logic               w_last_beat;

    // The LUT looks up the latched note; it is registered, so the step is
    // ready by the LOAD -> PLAY edge.
    note_step_lut u_lut (
        .clk    (clk),
        .reset  (reset),
        .i_note (r_note),
        .o_step (w_lut_step)
    );

    assign w_beat_en = bus.beat & bus.play;
    assign w_tick_en = bus.sample_tick & bus.play;
    assign w_cnt_inc = r_beat_cnt + DUR_W'(1);

    // Expiry is detected on the increment that lands on the duration, so the
    // counter never needs to go past the largest duration value.
    assign w_last_beat = (r_state == NP_PLAY) && w_beat_en && (w_cnt_inc == r_dur);

    assign w_step_out = (r_state == NP_PLAY) ? w_lut_step : '0;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.new_note) begin
            w_state_nxt = NP_LOAD;
        end else begin
            case (r_state)
                NP_IDLE: w_state_nxt = NP_IDLE;
                NP_LOAD: w_state_nxt = (r_dur == '0) ? NP_DONE : NP_PLAY;
                NP_PLAY: w_state_nxt = w_last_beat ? NP_DONE : NP_PLAY;
                NP_DONE: w_state_nxt = NP_IDLE;
                default: w_state_nxt = NP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= NP_IDLE;
            r_note     <= '0;
            r_dur      <= '0;
            r_meta     <= '0;
            r_beat_cnt <= '0;
            r_phase    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (bus.new_note) begin
                r_note <= bus.note;
                r_dur  <= bus.duration;
                r_meta <= bus.metadata;
            end

            if (r_state == NP_LOAD) begin
                r_beat_cnt <= '0;
                r_phase    <= '0;
            end else if ((r_state == NP_PLAY) && !bus.new_note) begin
                // Beat and tick are independent; both may land in one cycle.
                if (w_beat_en) begin
                    r_beat_cnt <= w_cnt_inc;
                end
                if (w_tick_en) begin
                    r_phase <= phase_advance(r_phase, w_step_out);
                end
            end
        end
    end

    assign bus.note_done    = (r_state == NP_DONE);
    assign bus.busy         = (r_state == NP_LOAD) || (r_state == NP_PLAY);
    assign bus.cur_metadata = r_meta;
    assign bus.step_size    = w_step_out;
    assign bus.phase        = r_phase;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_note_player_fsm.sv
// -----------------------------------------------------------------------------
// tb_note_player_fsm
// Directed bench for note_player_fsm. Inputs change just after the falling
// edge, outputs are observed at the falling edge after each rising edge.
// Expected values are hand-computed from the step table anchors
// (note 49 -> 38449, note 37 -> 19224, note 61 -> 76898, note 1 -> 2403).
// -----------------------------------------------------------------------------
module tb_note_player_fsm;

    logic clk;
    logic reset;

    note_player_fsm_if bus ();

    note_player_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_checks  = 0;
    int n_pass    = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Advance one full clock; counts note_done cycles as they are observed.
    task automatic cyc();
        @(negedge clk);
        if (bus.note_done === 1'b1) done_seen++;
    endtask

    task automatic beat_pulse();
        bus.beat = 1'b1;
        cyc();
        bus.beat = 1'b0;
    endtask

    // Presents a note for one cycle; returns at the negedge of the LOAD cycle.
    task automatic load_note(input int n, input int d, input int m);
        bus.note     = 6'(n);
        bus.duration = 6'(d);
        bus.metadata = 3'(m);
        bus.new_note = 1'b1;
        cyc();
        bus.new_note = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset           = 1'b0;
        bus.play        = 1'b0;
        bus.new_note    = 1'b0;
        bus.note        = '0;
        bus.duration    = '0;
        bus.metadata    = '0;
        bus.beat        = 1'b0;
        bus.sample_tick = 1'b0;

        // Reset state
        repeat (3) cyc();
        chk("rst_state", 32'(bus.dbg_state), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.note_done), 0);
        chk("rst_step",  32'(bus.step_size), 0);
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_meta",  32'(bus.cur_metadata), 0);

        reset = 1'b1;
        repeat (100) cyc();
        chk("quiet_state", 32'(bus.dbg_state), 0);
        chk("quiet_busy",  32'(bus.busy), 0);
        chk("quiet_step",  32'(bus.step_size), 0);
        chk("quiet_phase", 32'(bus.phase), 0);
        chk("quiet_done_count", 32'(done_seen), 0);

        // A: note 49 for 3 beats
        bus.play = 1'b1;
        load_note(49, 3, 5);
        chk("a_load_state", 32'(bus.dbg_state), 1);
        chk("a_load_busy",  32'(bus.busy), 1);
        chk("a_load_step",  32'(bus.step_size), 0);
        chk("a_load_meta",  32'(bus.cur_metadata), 5);
        cyc();
        chk("a_play_state", 32'(bus.dbg_state), 2);
        chk("a_play_step",  32'(bus.step_size), 38449);
        beat_pulse(); cyc();
        beat_pulse(); cyc();
        chk("a_beat2_busy", 32'(bus.busy), 1);
        chk("a_beat2_done", 32'(bus.note_done), 0);
        beat_pulse();
        chk("a_done_pulse", 32'(bus.note_done), 1);
        chk("a_done_busy",  32'(bus.busy), 0);
        chk("a_done_step",  32'(bus.step_size), 0);
        cyc();
        chk("a_idle_state", 32'(bus.dbg_state), 0);
        chk("a_idle_done",  32'(bus.note_done), 0);
        chk("a_done_count", 32'(done_seen), 1);

        // B: phase accumulation, pause and resume
        load_note(49, 3, 1);
        cyc();
        chk("b_phase_start", 32'(bus.phase), 0);
        bus.sample_tick = 1'b1;
        repeat (10) cyc();
        bus.sample_tick = 1'b0;
        chk("b_phase_10", 32'(bus.phase), 384490);
        beat_pulse();
        bus.play = 1'b0;
        bus.beat = 1'b1;
        bus.sample_tick = 1'b1;
        cyc();
        bus.beat = 1'b0;
        repeat (9) cyc();
        bus.sample_tick = 1'b0;
        beat_pulse();
        chk("b_pause_phase", 32'(bus.phase), 384490);
        chk("b_pause_state", 32'(bus.dbg_state), 2);
        chk("b_pause_step",  32'(bus.step_size), 38449);
        chk("b_pause_count", 32'(done_seen), 1);
        bus.play = 1'b1;
        beat_pulse();
        chk("b_resume_state", 32'(bus.dbg_state), 2);
        chk("b_resume_done",  32'(bus.note_done), 0);
        bus.beat = 1'b1;
        bus.sample_tick = 1'b1;
        cyc();
        bus.beat = 1'b0;
        bus.sample_tick = 1'b0;
        chk("b_done_pulse", 32'(bus.note_done), 1);
        chk("b_beat_tick_phase", 32'(bus.phase), 422939);
        cyc();
        chk("b_idle_state", 32'(bus.dbg_state), 0);
        chk("b_idle_phase", 32'(bus.phase), 422939);
        chk("b_done_count", 32'(done_seen), 2);

        // C: zero duration
        load_note(37, 0, 3);
        chk("c_load_state", 32'(bus.dbg_state), 1);
        chk("c_load_step",  32'(bus.step_size), 0);
        cyc();
        chk("c_done_pulse", 32'(bus.note_done), 1);
        chk("c_done_step",  32'(bus.step_size), 0);
        chk("c_phase_clr",  32'(bus.phase), 0);
        chk("c_meta",       32'(bus.cur_metadata), 3);
        cyc();
        chk("c_idle_state", 32'(bus.dbg_state), 0);
        chk("c_done_count", 32'(done_seen), 3);

        // D: retrigger mid-note
        load_note(37, 5, 2);
        cyc();
        chk("d_step_37", 32'(bus.step_size), 19224);
        beat_pulse(); cyc();
        beat_pulse(); cyc();
        load_note(61, 1, 6);
        chk("d_retrig_state", 32'(bus.dbg_state), 1);
        chk("d_retrig_done",  32'(bus.note_done), 0);
        chk("d_retrig_meta",  32'(bus.cur_metadata), 6);
        cyc();
        chk("d_step_61", 32'(bus.step_size), 76898);
        chk("d_no_done_count", 32'(done_seen), 3);
        beat_pulse();
        chk("d_done_pulse", 32'(bus.note_done), 1);
        cyc();
        chk("d_done_count", 32'(done_seen), 4);

        // E: final beat and new_note together -> new_note wins
        load_note(49, 1, 4);
        cyc();
        bus.beat = 1'b1;
        load_note(1, 2, 7);
        bus.beat = 1'b0;
        chk("e_state", 32'(bus.dbg_state), 1);
        chk("e_done",  32'(bus.note_done), 0);
        chk("e_meta",  32'(bus.cur_metadata), 7);
        cyc();
        chk("e_step_1", 32'(bus.step_size), 2403);
        chk("e_done_count", 32'(done_seen), 4);

        // G: phase wrap and 63-beat duration
        load_note(61, 63, 0);
        cyc();
        bus.sample_tick = 1'b1;
        repeat (54) cyc();
        chk("g_phase_54", 32'(bus.phase), 4152492);
        cyc();
        bus.sample_tick = 1'b0;
        chk("g_phase_wrap", 32'(bus.phase), 35086);
        bus.beat = 1'b1;
        repeat (62) cyc();
        chk("g_beat62_state", 32'(bus.dbg_state), 2);
        chk("g_beat62_done",  32'(bus.note_done), 0);
        cyc();
        bus.beat = 1'b0;
        chk("g_beat63_done",  32'(bus.note_done), 1);
        chk("g_beat63_state", 32'(bus.dbg_state), 3);
        cyc();
        chk("g_done_count", 32'(done_seen), 5);

        // F: asynchronous reset in the middle of a note
        load_note(1, 10, 5);
        cyc();
        bus.sample_tick = 1'b1;
        repeat (3) cyc();
        bus.sample_tick = 1'b0;
        chk("f_phase_pre", 32'(bus.phase), 7209);
        chk("f_busy_pre",  32'(bus.busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("f_async_state", 32'(bus.dbg_state), 0);
        chk("f_async_busy",  32'(bus.busy), 0);
        chk("f_async_step",  32'(bus.step_size), 0);
        chk("f_async_phase", 32'(bus.phase), 0);
        chk("f_async_meta",  32'(bus.cur_metadata), 0);
        chk("f_async_done",  32'(bus.note_done), 0);
        cyc();
        cyc();
        reset = 1'b1;
        repeat (10) cyc();
        chk("f_post_state", 32'(bus.dbg_state), 0);
        chk("f_post_busy",  32'(bus.busy), 0);
        chk("f_done_count", 32'(done_seen), 5);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
